// File: rtl/gpc_popcount_pipe.sv
// rtl/gpc_popcount_pipe.sv - pipelined 6:3 GPC popcount with per-beat and burst-accumulate modes
module gpc_popcount_pipe #(
    parameter int N_IN   = 24,
    parameter int STAGES = 2,
    parameter int ACC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_sat
);

    localparam int SW    = $clog2(N_IN + 1);
    localparam int NG    = (N_IN + 5) / 6;
    localparam int NP    = NG * 6;
    localparam int T     = $clog2(NG) + 1;
    localparam int EXTRA = (STAGES > T) ? STAGES - T : 0;
    localparam int AW1   = ACC_W + 1;

    function automatic int nodes_at(input int k);
        return (NG + (1 << k) - 1) >> k;
    endfunction

    // Registers sit at evenly spaced levels; surplus stages become a delay chain after the root.
    function automatic logic reg_after(input int k);
        logic r;
        r = 1'b0;
        if (STAGES >= T) r = 1'b1;
        else
            for (int s = 0; s < STAGES; s++)
                if (((s + 1) * T) / STAGES - 1 == k) r = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] gpc63(input logic [5:0] b);
        logic s0, c0, s1, c1, k;
        s0 = b[0] ^ b[1] ^ b[2];
        c0 = (b[0] & b[1]) | (b[0] & b[2]) | (b[1] & b[2]);
        s1 = b[3] ^ b[4] ^ b[5];
        c1 = (b[3] & b[4]) | (b[3] & b[5]) | (b[4] & b[5]);
        k  = s0 & s1;
        return {(c0 & c1) | (c0 & k) | (c1 & k), c0 ^ c1 ^ k, s0 ^ s1};
    endfunction

    logic w_en;
    assign w_en     = ~(out_valid & ~out_ready);
    assign in_ready = w_en;

    logic [NP-1:0] r_data;
    logic          r_v, r_l, r_m, r_in_acc;

    // r_in_acc tracks an open burst on the input side so later beats inherit mode=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_v      <= 1'b0;
            r_l      <= 1'b0;
            r_m      <= 1'b0;
            r_in_acc <= 1'b0;
        end else if (w_en) begin
            r_v <= in_valid;
            if (in_valid) begin
                r_data   <= NP'(in_data);
                r_l      <= in_last;
                r_m      <= mode | r_in_acc;
                r_in_acc <= (mode | r_in_acc) & ~in_last;
            end
        end
    end

    for (genvar k = 0; k < T; k++) begin : g_lvl
        localparam int NK = nodes_at(k);
        logic [SW-1:0] w_c [0:NK-1];
        logic [SW-1:0] w_o [0:NK-1];
        logic          w_vi, w_li, w_mi, w_vo, w_lo, w_mo;

        if (k == 0) begin : g_gpc
            for (genvar i = 0; i < NK; i++) begin : g_n
                assign w_c[i] = SW'(gpc63(r_data[6*i +: 6]));
            end
            assign w_vi = r_v;
            assign w_li = r_l;
            assign w_mi = r_m;
        end else begin : g_add
            localparam int NPK = nodes_at(k - 1);
            for (genvar i = 0; i < NK; i++) begin : g_n
                if (2 * i + 1 < NPK) begin : g_pair
                    assign w_c[i] = g_lvl[k-1].w_o[2*i] + g_lvl[k-1].w_o[2*i+1];
                end else begin : g_pass
                    assign w_c[i] = g_lvl[k-1].w_o[2*i];
                end
            end
            assign w_vi = g_lvl[k-1].w_vo;
            assign w_li = g_lvl[k-1].w_lo;
            assign w_mi = g_lvl[k-1].w_mo;
        end

        if (reg_after(k)) begin : g_reg
            logic [SW-1:0] r_q [0:NK-1];
            logic          r_qv, r_ql, r_qm;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NK; i++) r_q[i] <= '0;
                    r_qv <= 1'b0;
                    r_ql <= 1'b0;
                    r_qm <= 1'b0;
                end else if (w_en) begin
                    for (int i = 0; i < NK; i++) r_q[i] <= w_c[i];
                    r_qv <= w_vi;
                    r_ql <= w_li;
                    r_qm <= w_mi;
                end
            end
            assign w_o  = r_q;
            assign w_vo = r_qv;
            assign w_lo = r_ql;
            assign w_mo = r_qm;
        end else begin : g_comb
            assign w_o  = w_c;
            assign w_vo = w_vi;
            assign w_lo = w_li;
            assign w_mo = w_mi;
        end
    end

    logic [SW-1:0] w_tc;
    logic          w_tv, w_tl, w_tm;

    if (EXTRA > 0) begin : g_extra
        logic [SW-1:0]    r_xc [0:EXTRA-1];
        logic [EXTRA-1:0] r_xv, r_xl, r_xm;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int e = 0; e < EXTRA; e++) r_xc[e] <= '0;
                r_xv <= '0;
                r_xl <= '0;
                r_xm <= '0;
            end else if (w_en) begin
                for (int e = EXTRA - 1; e > 0; e--) begin
                    r_xc[e] <= r_xc[e-1];
                    r_xv[e] <= r_xv[e-1];
                    r_xl[e] <= r_xl[e-1];
                    r_xm[e] <= r_xm[e-1];
                end
                r_xc[0] <= g_lvl[T-1].w_o[0];
                r_xv[0] <= g_lvl[T-1].w_vo;
                r_xl[0] <= g_lvl[T-1].w_lo;
                r_xm[0] <= g_lvl[T-1].w_mo;
            end
        end
        assign w_tc = r_xc[EXTRA-1];
        assign w_tv = r_xv[EXTRA-1];
        assign w_tl = r_xl[EXTRA-1];
        assign w_tm = r_xm[EXTRA-1];
    end else begin : g_direct
        assign w_tc = g_lvl[T-1].w_o[0];
        assign w_tv = g_lvl[T-1].w_vo;
        assign w_tl = g_lvl[T-1].w_lo;
        assign w_tm = g_lvl[T-1].w_mo;
    end

    typedef enum logic {S_IDLE, S_ACC} state_t;
    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sum_c, w_cnt;
    logic             w_ovf;

    assign w_cnt   = ACC_W'(w_tc);
    assign w_sum   = {1'b0, r_acc} + AW1'(w_tc);
    assign w_ovf   = w_sum[ACC_W];
    assign w_sum_c = w_ovf ? '1 : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (w_en) begin
            out_valid <= 1'b0;
            if (w_tv) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_tm && !w_tl) begin
                            r_acc   <= w_cnt;
                            r_sat   <= 1'b0;
                            r_state <= S_ACC;
                        end else begin
                            out_valid <= 1'b1;
                            out_count <= w_cnt;
                            out_sat   <= 1'b0;
                        end
                    end
                    S_ACC: begin
                        if (w_tl) begin
                            out_valid <= 1'b1;
                            out_count <= w_sum_c;
                            out_sat   <= r_sat | w_ovf;
                            r_acc     <= '0;
                            r_sat     <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_acc <= w_sum_c;
                            r_sat <= r_sat | w_ovf;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpc_popcount_pipe.sv
// tb/tb_gpc_popcount_pipe.sv - table-driven scoreboard bench for gpc_popcount_pipe
module tb_gpc_popcount_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_in_last, a_mode, a_out_valid, a_out_ready, a_out_sat;
    logic [23:0] a_in_data;
    logic [15:0] a_out_count;
    logic        b_in_valid, b_in_ready, b_in_last, b_mode, b_out_valid, b_out_ready, b_out_sat;
    logic [23:0] b_in_data;
    logic [4:0]  b_out_count;

    gpc_popcount_pipe #(.N_IN(24), .STAGES(2), .ACC_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_last(a_in_last), .mode(a_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_count(a_out_count), .out_sat(a_out_sat)
    );

    gpc_popcount_pipe #(.N_IN(24), .STAGES(2), .ACC_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(b_in_last), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_count(b_out_count), .out_sat(b_out_sat)
    );

    typedef struct {
        logic [23:0] data;
        logic        last;
        logic        mode;
        logic        emit;
        logic [15:0] cnt;
        logic        sat;
    } vec_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic        sat;
    } exp_t;

    vec_t        tv [0:28];
    exp_t        qa [$];
    exp_t        qb [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_pop = -1;
    logic        gap_on = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_cnt = '0;

    function automatic vec_t mk(input logic [23:0] d, input logic l, input logic m,
                                input logic e, input logic [15:0] c, input logic s);
        vec_t v;
        v.data = d; v.last = l; v.mode = m; v.emit = e; v.cnt = c; v.sat = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_unexpected_out", 32'(a_out_valid), 32'd0);
            else begin
                e = qa.pop_front();
                chk("a_count", 32'(a_out_count), 32'(e.cnt));
                chk("a_sat", 32'(a_out_sat), 32'(e.sat));
                if (gap_on && last_pop >= 0) chk("b2b_gap", 32'(cyc - last_pop), 32'd1);
                last_pop = cyc;
            end
        end
        if (a_out_valid && !a_out_ready) begin
            chk("stall_in_ready", 32'(a_in_ready), 32'd0);
            if (prev_stall) chk("stall_hold", 32'(a_out_count), 32'(prev_cnt));
            prev_stall = 1'b1;
            prev_cnt   = a_out_count;
        end else prev_stall = 1'b0;
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_unexpected_out", 32'(b_out_valid), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_count", 32'(b_out_count), 32'(e.cnt));
                chk("b_sat", 32'(b_out_sat), 32'(e.sat));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Drives rows lo..hi-1 into instance sel; out_ready of A is low for cycles st..st+sl-1.
    task automatic run(input int sel, input int lo, input int hi, input int st, input int sl);
        int   idx;
        int   c;
        logic acc;
        exp_t e;
        idx = lo;
        c   = 0;
        while (idx < hi && c < 200) begin
            if (sel == 0) begin
                a_out_ready = !(c >= st && c < st + sl);
                a_in_valid = 1'b1; a_in_data = tv[idx].data;
                a_in_last = tv[idx].last; a_mode = tv[idx].mode;
            end else begin
                b_in_valid = 1'b1; b_in_data = tv[idx].data;
                b_in_last = tv[idx].last; b_mode = tv[idx].mode;
            end
            @(negedge clk);
            check_out();
            acc = (sel == 0) ? a_in_ready : b_in_ready;
            if (acc) begin
                if (tv[idx].emit) begin
                    e.cnt = tv[idx].cnt;
                    e.sat = tv[idx].sat;
                    if (sel == 0) qa.push_back(e);
                    else qb.push_back(e);
                end
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
            c++;
        end
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        chk("run_done", 32'(idx), 32'(hi));
    endtask

    initial begin
        exp_t e;
        tv[0]  = mk(24'hFFFFFF, 0, 0, 1, 24, 0);
        tv[1]  = mk(24'h000000, 0, 0, 1, 0, 0);
        tv[2]  = mk(24'hA5A5A5, 0, 0, 1, 12, 0);
        tv[3]  = mk(24'h000001, 0, 0, 1, 1, 0);
        tv[4]  = mk(24'h000003, 0, 0, 1, 2, 0);
        tv[5]  = mk(24'h000007, 0, 0, 1, 3, 0);
        tv[6]  = mk(24'h00000F, 0, 0, 1, 4, 0);
        tv[7]  = mk(24'h123456, 0, 0, 1, 9, 0);
        tv[8]  = mk(24'h800000, 0, 0, 1, 1, 0);
        tv[9]  = mk(24'h0F0F0F, 0, 0, 1, 12, 0);
        tv[10] = mk(24'hFFFF00, 0, 0, 1, 16, 0);
        tv[11] = mk(24'h00FF00, 0, 0, 1, 8, 0);
        tv[12] = mk(24'h555555, 0, 0, 1, 12, 0);
        tv[13] = mk(24'h000007, 0, 0, 1, 3, 0);
        tv[14] = mk(24'hC00003, 0, 0, 1, 4, 0);
        tv[15] = mk(24'hFFFFFF, 0, 1, 0, 0, 0);
        tv[16] = mk(24'h00000F, 0, 0, 0, 0, 0);
        tv[17] = mk(24'h000001, 1, 0, 1, 29, 0);
        tv[18] = mk(24'h000F0F, 1, 1, 1, 8, 0);
        tv[19] = mk(24'h00000F, 0, 0, 1, 4, 0);
        tv[20] = mk(24'hFFFFFF, 0, 1, 0, 0, 0);
        tv[21] = mk(24'hFFFFFF, 0, 1, 0, 0, 0);
        tv[22] = mk(24'h000000, 1, 1, 1, 31, 1);
        tv[23] = mk(24'h000007, 1, 1, 1, 3, 0);
        tv[24] = mk(24'hFFFFFF, 0, 1, 0, 0, 0);
        tv[25] = mk(24'h0000FF, 0, 1, 0, 0, 0);
        tv[26] = mk(24'h00000F, 0, 1, 0, 0, 0);
        tv[27] = mk(24'h000001, 1, 1, 0, 0, 0);
        tv[28] = mk(24'h000003, 1, 1, 1, 2, 0);

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_mode = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_mode = 1'b0; b_out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_count", 32'(a_out_count), 32'd0);
        chk("rst_out_sat", 32'(a_out_sat), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        idle(2);

        a_in_valid = 1'b1; a_in_data = tv[0].data; a_in_last = 1'b0; a_mode = 1'b0;
        @(negedge clk);
        check_out();
        chk("lat_accept", 32'(a_in_ready), 32'd1);
        e.cnt = tv[0].cnt;
        e.sat = tv[0].sat;
        qa.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_valid", 32'(a_out_valid), 32'(i == 3));
            check_out();
            @(posedge clk);
            #1;
            cyc++;
        end

        run(0, 1, 3, -1, 0);
        idle(6);
        gap_on = 1'b1;
        last_pop = -1;
        run(0, 3, 7, -1, 0);
        idle(6);
        gap_on = 1'b0;
        run(0, 7, 15, 4, 5);
        idle(8);
        run(0, 15, 20, -1, 0);
        idle(8);
        run(1, 20, 24, -1, 0);
        idle(8);

        run(0, 24, 28, -1, 0);
        rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 32'(a_out_valid), 32'd0);
        chk("midrst_out_count", 32'(a_out_count), 32'd0);
        chk("midrst_out_sat", 32'(a_out_sat), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        run(0, 28, 29, -1, 0);
        idle(10);

        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
